// File: rtl/pipe_defs.sv
// Shared definitions for the pipeline hazard logic: stage timing encodings,
// MDU latency defaults and register index width.
package pipe_defs;

    localparam int REG_IDX_W = 5;
    localparam int STALL_CNT_W = 32;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    // Tuse: cycles until the D-stage instruction consumes a source operand.
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until a downstream instruction produces its result.
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // A source operand must wait when a younger-result producer writes it
    // later than the consumer needs it. Register 0 is hardwired and never waits.
    function automatic logic src_hazard(
        input logic [REG_IDX_W-1:0] src,
        input logic [1:0]           tuse,
        input logic [REG_IDX_W-1:0] e_wa,
        input logic [1:0]           e_tnew,
        input logic [REG_IDX_W-1:0] m_wa,
        input logic [1:0]           m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (src == e_wa) && (e_tnew > tuse);
        m_hit = (src == m_wa) && (m_tnew > tuse);
        return (src != '0) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: counts down the MDU latency after an issue and
// reports busy while the result is still pending.
module md_busy_timer
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A start is accepted only from idle; a start while counting is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (start && (cnt_q == '0)) begin
            cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard and stall controller: freezes F/D and bubbles E on register
// or MDU hazards, and keeps a saturating stall-cycle count.
module stall_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_IDX_W-1:0]   D_rs,
    input  logic [REG_IDX_W-1:0]   D_rt,
    input  logic [1:0]             D_rs_tuse,
    input  logic [1:0]             D_rt_tuse,
    input  logic                   D_is_md,
    input  logic [REG_IDX_W-1:0]   E_wa,
    input  logic [1:0]             E_tnew,
    input  logic [REG_IDX_W-1:0]   M_wa,
    input  logic [1:0]             M_tnew,
    input  logic                   E_md_start,
    input  logic                   E_md_is_div,
    output logic                   F_pc_en,
    output logic                   D_reg_en,
    output logic                   E_reg_clr,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic stall;

    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_is_div),
        .busy   (md_busy)
    );

    // An md instruction in D also waits during the issue cycle itself, since
    // busy only rises on the following cycle.
    always_comb begin
        rs_stall = src_hazard(D_rs, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew);
        rt_stall = src_hazard(D_rt, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew);
        md_stall = D_is_md && (md_busy || E_md_start);
        stall    = rs_stall || rt_stall || md_stall;
    end

    assign F_pc_en   = ~stall;
    assign D_reg_en  = ~stall;
    assign E_reg_clr = stall;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed and random cycles scored against a
// cycle-indexed reference model through an expected-value queue.
module tb_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int W      = 36;

  logic        clk;
  logic        rst;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        f_pc_en, d_reg_en, e_reg_clr, md_busy;
  logic [31:0] stall_cycles;

  logic [W-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  // reference model state: busy window as absolute cycle indices
  longint m_cyc;
  longint m_busy_start;
  longint m_busy_end;
  longint m_cnt;

  stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (rst),
    .D_rs         (d_rs),
    .D_rt         (d_rt),
    .D_rs_tuse    (d_rs_tuse),
    .D_rt_tuse    (d_rt_tuse),
    .D_is_md      (d_is_md),
    .E_wa         (e_wa),
    .E_tnew       (e_tnew),
    .M_wa         (m_wa),
    .M_tnew       (m_tnew),
    .E_md_start   (e_md_start),
    .E_md_is_div  (e_md_is_div),
    .F_pc_en      (f_pc_en),
    .D_reg_en     (d_reg_en),
    .E_reg_clr    (e_reg_clr),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit waits_on(input int src, input int tuse, input int pw, input int ptnew);
    return (src != 0) && (src == pw) && (ptnew > tuse);
  endfunction

  task automatic model_reset();
    m_busy_start = 0;
    m_busy_end   = -1;
    m_cnt        = 0;
  endtask

  // ---------------- driver ----------------
  task automatic apply_and_push(input logic [4:0] rs, input logic [1:0] rs_tu,
                                input logic [4:0] rt, input logic [1:0] rt_tu,
                                input logic is_md,
                                input logic [4:0] ew, input logic [1:0] etn,
                                input logic [4:0] mw, input logic [1:0] mtn,
                                input logic start, input logic is_div);
    bit busy, reg_wait, stall;
    d_rs = rs; d_rs_tuse = rs_tu; d_rt = rt; d_rt_tuse = rt_tu;
    d_is_md = is_md; e_wa = ew; e_tnew = etn; m_wa = mw; m_tnew = mtn;
    e_md_start = start; e_md_is_div = is_div;
    busy = (m_cyc >= m_busy_start) && (m_cyc <= m_busy_end);
    reg_wait = waits_on(rs, rs_tu, ew, etn) || waits_on(rs, rs_tu, mw, mtn) ||
               waits_on(rt, rt_tu, ew, etn) || waits_on(rt, rt_tu, mw, mtn);
    stall = reg_wait || (is_md && (busy || start));
    exp_q.push_back({~stall, ~stall, stall, busy, m_cnt[31:0]});
    if (stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (start && !busy) begin
      m_busy_start = m_cyc + 1;
      m_busy_end   = m_cyc + (is_div ? DIV_N : MULT_N);
    end
    m_cyc++;
  endtask

  task automatic drive_cycle(input logic [4:0] rs, input logic [1:0] rs_tu,
                             input logic [4:0] rt, input logic [1:0] rt_tu,
                             input logic is_md,
                             input logic [4:0] ew, input logic [1:0] etn,
                             input logic [4:0] mw, input logic [1:0] mtn,
                             input logic start, input logic is_div);
    @(posedge clk);
    #1;
    apply_and_push(rs, rs_tu, rt, rt_tu, is_md, ew, etn, mw, mtn, start, is_div);
  endtask

  task automatic idle_cycle();
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      exp_v = exp_q.pop_front();
      act_v = {f_pc_en, d_reg_en, e_reg_clr, md_busy, stall_cycles};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs @%0t: got pc_en/d_en/clr/busy=%b cnt=%0h, required %b cnt=%0h",
                 $time, act_v[35:32], act_v[31:0], exp_v[35:32], exp_v[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_cyc   = 0;
    model_reset();
    rst = 1'b1;
    d_rs = 0; d_rt = 0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; d_is_md = 0;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0; e_md_start = 0; e_md_is_div = 0;
    #3;
    check_now("reset_pc_en", {31'd0, f_pc_en}, 32'd1);
    check_now("reset_d_en", {31'd0, d_reg_en}, 32'd1);
    check_now("reset_clr", {31'd0, e_reg_clr}, 32'd0);
    check_now("reset_busy", {31'd0, md_busy}, 32'd0);
    check_now("reset_cnt", stall_cycles, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;

    // quiet pipeline
    repeat (3) idle_cycle();

    // load-use on rs from E, then from M, then resolved
    drive_cycle(5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    drive_cycle(5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0);
    drive_cycle(5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0, 1'b0);
    // register 0 never stalls; equal tnew/tuse does not stall
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    drive_cycle(5'd5, 2'd1, 5'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
    // rt hazard from M
    drive_cycle(5'd0, 2'd3, 5'd9, 2'd0, 1'b0, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0, 1'b0);

    // mult issue with md instr held in D, then div
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    repeat (MULT_N + 1) drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    repeat (DIV_N + 1) drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    // back-to-back: start retried every cycle while busy, only idle-time starts load
    repeat (2 * MULT_N + 3) drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    repeat (MULT_N + 1) idle_cycle();

    // async reset in the middle of a div
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    repeat (3) drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_now("async_reset_busy", {31'd0, md_busy}, 32'd0);
    check_now("async_reset_cnt", stall_cycles, 32'd0);
    check_now("async_reset_pc_en", {31'd0, f_pc_en}, 32'd1);
    model_reset();
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    drive_cycle(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);

    // randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 400; i++) begin
      logic start;
      start = ($urandom_range(0, 5) == 0);
      drive_cycle(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                  start, 1'($urandom_range(0, 1)));
    end

    // saturation: let the MDU drain, then preload the counter while idle
    repeat (DIV_N + 2) idle_cycle();
    @(negedge clk); #1;
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    m_cnt = 64'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.stall_cycles_q;
    apply_and_push(5'd7, 2'd0, 5'd0, 2'd3, 1'b0, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    repeat (4) drive_cycle(5'd7, 2'd0, 5'd0, 2'd3, 1'b0, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
    idle_cycle();

    @(negedge clk); #1;
    check_now("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
